inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the RV32I CPU: owns the program counter, issues requests to instruction memory over a ready/valid handshake, holds the returned instruction until the decode/execute side consumes it, and applies branch/jump redirects and pipeline flushes. It sits directly upstream of `imm_gen` and drives its `inst` input with `inst[31:7]`. It also feeds the register file, the control unit and the branch/ALU PC operand.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `imem_req`  out  1  — fetch request valid.
- `imem_addr`  out  32  — fetch address; equals `pc`.
- `imem_ready`  in  1  — memory accepts the request this cycle.
- `imem_rvalid`  in  1  — read data valid.
- `imem_rdata`  in  32  — instruction word.
- `stall`  in  1  — downstream cannot consume the held instruction.
- `br_take`  in  1  — the consumed instruction redirects the PC.
- `br_target`  in  32  — redirect target.
- `flush`  in  1  — unconditional redirect, valid in any state.
- `flush_pc`  in  32  — flush target.
- `inst_valid`  out  1  — `inst` and `pc` describe a live instruction.
- `inst`  out  32  — held instruction.
- `imm_inst`  out  25  — `inst[31:7]`, wired to `imm_gen`.
- `pc`  out  32  — address of the current or held instruction.
- `pc_plus4`  out  32  — `pc + 4`, the link value for JAL/JALR.

## Operation
- FSM states: FETCH, WAIT, HOLD.
- **FETCH**
  - `imem_req`=1.
  - Go to WAIT when `imem_ready`=1.
- **WAIT**
  - `imem_req`=0.
  - On `imem_rvalid`=1 and `drop`=1: clear `drop`, go to FETCH.
  - On `imem_rvalid`=1 and `drop`=0: latch `imem_rdata` into `inst`, go to HOLD.
- **HOLD**
  - `inst_valid`=1.
  - Consume occurs when `stall`=0.
  - On consume, `pc` ← `br_take ? br_target : pc+4`, then go to FETCH.
  - `br_take` is ignored outside a consume cycle.
- **Flush** (priority over consume)
  - `pc` ← `flush_pc`.
  - `inst_valid` drops next cycle; go to FETCH.
  - In WAIT: set `drop`, stay in WAIT until the response arrives, then go to FETCH.
  - In FETCH with `imem_ready`=1 in the same cycle: the old request is accepted, so set `drop` and go to WAIT.
- `br_target[1:0]` and `flush_pc[1:0]` are forced to 2'b00 when loaded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `imem_rvalid` outside WAIT is ignored.
- A new request is never issued while one is outstanding.

## Timing
- **Reset values:**
  - state = FETCH, `pc` = `RESET_PC`, `drop` = 0.
  - `inst` = 32'h0000_0013 (NOP), `inst_valid` = 0, `imem_req` = 0 while `rst` is high.
- **First request:** `imem_req` rises in the first cycle after `rst` deasserts.
- **Latency:** `imem_rdata` captured on the `imem_rvalid` edge → `inst_valid`=1 in the next cycle.
  - Best case request→`inst_valid` is 2 cycles (ready in cycle 0, rvalid in cycle 1).
- **Request stability:** `imem_addr` is stable while `imem_req`=1 and `imem_ready`=0, except on a flush, which may change the address before acceptance.
- **Consume:** `inst`, `pc` and `inst_valid` hold while `stall`=1. On consume, `inst_valid`=0 and the new `pc` appear the following cycle.
- **Throughput:** one instruction per 3 cycles minimum; no prefetch.
- **Reset mid-operation:** returns to reset values immediately. Any in-flight response is ignored because the FSM is in FETCH.

## Structure
- Shared `cpu_pkg` holds:
  - `NOP_INST` = 32'h0000_0013
  - default `RESET_PC`
  - fetch state enum `fetch_state_t`
- One sub-module, `pc_next`: a combinational next-PC select (pc+4 / `br_target` / `flush_pc`, low bits cleared, flush > branch > sequential).
- The FSM and registers stay in `inst_fetch`.

## Test plan
- **Reset and first fetch:** `RESET_PC`=32'h100; release `rst`, `imem_ready`=1, rvalid next cycle with 32'h00500093 → `inst_valid`=1, `pc`=32'h100, `imm_inst`=25'h00A001, `pc_plus4`=32'h104.
- **Stall then sequential consume:** `stall`=1 for 3 cycles → outputs frozen; `stall`=0 → next `imem_addr`=32'h104.
- **Branch on consume:** `br_take`=1, `br_target`=32'h203 → next `imem_addr`=32'h200. `br_take` pulsed during WAIT has no effect.
- **Flush during WAIT:** `flush`=1, `flush_pc`=32'h400 while waiting; the late rvalid returns 32'hDEADBEEF → data dropped, `inst_valid` stays 0, next request addr 32'h400.
- **Flush coincident with `imem_ready` in FETCH:** old request is accepted, its response is discarded, then the fetch goes to `flush_pc`.
- **Wrap and async reset:** `pc`=32'hFFFF_FFFC consumed → addr 32'h0. Asserting `rst` mid-WAIT → `inst_valid`=0 and `pc`=`RESET_PC` without a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset constants, PC alignment helper.
package cpu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; redirect targets never carry low bits into the PC.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response bus between fetch and memory.
interface inst_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: flush beats branch beats sequential.
import cpu_pkg::*;

module pc_next (
  input  logic [31:0] i_pc,
  input  logic        i_br_take,
  input  logic [31:0] i_br_target,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic [31:0] o_pc_next,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] w_pc_plus4;

  // 32-bit modulo increment, so the top word wraps to zero.
  assign w_pc_plus4 = i_pc + 32'd4;
  assign o_pc_plus4 = w_pc_plus4;

  // Priority select of the value loaded into the PC.
  always_comb begin
    o_pc_next = w_pc_plus4;
    if (i_flush) begin
      o_pc_next = align_pc(i_flush_pc);
    end else if (i_br_take) begin
      o_pc_next = align_pc(i_br_target);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC owner, one outstanding imem request, holds the fetched
// instruction until consumed, applies branch redirects and flushes.
import cpu_pkg::*;

module inst_fetch #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_if.master        imem,
  input  logic                i_stall,
  input  logic                i_br_take,
  input  logic [31:0]         i_br_target,
  input  logic                i_flush,
  input  logic [31:0]         i_flush_pc,
  output logic                o_inst_valid,
  output logic [31:0]         o_inst,
  output logic [24:0]         o_imm_inst,
  output logic [31:0]         o_pc,
  output logic [31:0]         o_pc_plus4
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  w_inst_next;
  logic         r_drop;
  logic         w_drop_next;
  logic         w_pc_load;
  logic         w_br_sel;
  logic [31:0]  w_pc_next;

  pc_next u_pc_next (
    .i_pc        (r_pc),
    .i_br_take   (w_br_sel),
    .i_br_target (i_br_target),
    .i_flush     (i_flush),
    .i_flush_pc  (i_flush_pc),
    .o_pc_next   (w_pc_next),
    .o_pc_plus4  (o_pc_plus4)
  );

  // State, PC, held instruction and drop flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_inst  <= w_inst_next;
      r_drop  <= w_drop_next;
      if (w_pc_load) begin
        r_pc <= w_pc_next;
      end
    end
  end

  // Next-state logic; a flush always reloads the PC and wins over consume.
  always_comb begin
    w_state_next = r_state;
    w_inst_next  = r_inst;
    w_drop_next  = r_drop;
    w_pc_load    = 1'b0;
    w_br_sel     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (i_flush) begin
          w_pc_load = 1'b1;
        end
        if (imem.ready) begin
          // An accepted request on a flush cycle carries the stale address.
          w_drop_next  = i_flush;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_flush) begin
          w_pc_load = 1'b1;
        end
        if (imem.rvalid) begin
          if (r_drop || i_flush) begin
            w_drop_next  = 1'b0;
            w_state_next = S_FETCH;
          end else begin
            w_inst_next  = imem.rdata;
            w_state_next = S_HOLD;
          end
        end else if (i_flush) begin
          w_drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_flush) begin
          w_pc_load    = 1'b1;
          w_state_next = S_FETCH;
        end else if (!i_stall) begin
          w_pc_load    = 1'b1;
          w_br_sel     = i_br_take;
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Request is suppressed while reset is held even though the state reads FETCH.
  assign imem.req     = (r_state == S_FETCH) && !rst;
  assign imem.addr    = r_pc;
  assign o_inst_valid = (r_state == S_HOLD);
  assign o_inst       = r_inst;
  assign o_imm_inst   = r_inst[31:7];
  assign o_pc         = r_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with RESET_PC = 32'h100.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [24:0] imm_inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int checks = 0;
  int errors = 0;

  inst_fetch_if imem_bus ();

  inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_bus),
    .i_stall      (stall),
    .i_br_take    (br_take),
    .i_br_target  (br_target),
    .i_flush      (flush),
    .i_flush_pc   (flush_pc),
    .o_inst_valid (inst_valid),
    .o_inst       (inst),
    .o_imm_inst   (imm_inst),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_take = 1'b0; br_target = '0;
    flush = 1'b0; flush_pc = '0;
    imem_bus.ready = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
    tick();
    chk("reset_pc", pc, 32'h100);
    chk("reset_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_req", {31'd0, imem_bus.req}, 32'd0);
    chk("reset_inst", inst, 32'h13);

    // Reset and first fetch
    rst = 1'b0;
    #1;
    chk("first_req", {31'd0, imem_bus.req}, 32'd1);
    chk("first_addr", imem_bus.addr, 32'h100);
    imem_bus.ready = 1'b1;
    tick();
    imem_bus.ready = 1'b0;
    chk("wait_req", {31'd0, imem_bus.req}, 32'd0);
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h0050_0093;
    tick();
    imem_bus.rvalid = 1'b0;
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_pc", pc, 32'h100);
    chk("first_imm", {7'd0, imm_inst}, 32'h0000_A001);
    chk("first_pc4", pc_plus4, 32'h104);
    chk("first_inst", inst, 32'h0050_0093);
    $display("fetch pc=%h inst=%h", pc, inst);

    // Stall then sequential consume
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", pc, 32'h100);
      chk("stall_inst", inst, 32'h0050_0093);
    end
    stall = 1'b0;
    tick();
    chk("seq_valid", {31'd0, inst_valid}, 32'd0);
    chk("seq_addr", imem_bus.addr, 32'h104);
    chk("seq_req", {31'd0, imem_bus.req}, 32'd1);
    tick();
    chk("seq_addr_stable", imem_bus.addr, 32'h104);
    imem_bus.ready = 1'b1;
    tick();
    imem_bus.ready = 1'b0;
    // Branch pulsed while waiting is ignored
    br_take = 1'b1; br_target = 32'h300;
    tick();
    br_take = 1'b0;
    chk("br_wait_pc", pc, 32'h104);
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h0000_0013;
    tick();
    imem_bus.rvalid = 1'b0;
    chk("second_valid", {31'd0, inst_valid}, 32'd1);
    chk("second_pc", pc, 32'h104);
    $display("fetch pc=%h inst=%h", pc, inst);

    // Branch on consume
    br_take = 1'b1; br_target = 32'h203;
    tick();
    br_take = 1'b0;
    chk("br_addr", imem_bus.addr, 32'h200);
    chk("br_valid", {31'd0, inst_valid}, 32'd0);

    // Flush during WAIT
    imem_bus.ready = 1'b1;
    tick();
    imem_bus.ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h400;
    tick();
    flush = 1'b0;
    chk("flw_pc", pc, 32'h400);
    chk("flw_req", {31'd0, imem_bus.req}, 32'd0);
    tick();
    chk("flw_still_wait", {31'd0, imem_bus.req}, 32'd0);
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
    tick();
    imem_bus.rvalid = 1'b0;
    chk("flw_valid", {31'd0, inst_valid}, 32'd0);
    chk("flw_req2", {31'd0, imem_bus.req}, 32'd1);
    chk("flw_addr", imem_bus.addr, 32'h400);
    chk("flw_inst", inst, 32'h13);
    $display("flush in wait -> pc=%h", pc);

    // Flush coincident with ready in FETCH
    imem_bus.ready = 1'b1; flush = 1'b1; flush_pc = 32'h502;
    tick();
    imem_bus.ready = 1'b0; flush = 1'b0;
    chk("flf_pc", pc, 32'h500);
    chk("flf_req", {31'd0, imem_bus.req}, 32'd0);
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h1111_1111;
    tick();
    imem_bus.rvalid = 1'b0;
    chk("flf_valid", {31'd0, inst_valid}, 32'd0);
    chk("flf_req2", {31'd0, imem_bus.req}, 32'd1);
    chk("flf_addr", imem_bus.addr, 32'h500);
    imem_bus.ready = 1'b1;
    tick();
    imem_bus.ready = 1'b0;
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h2222_2222;
    tick();
    imem_bus.rvalid = 1'b0;
    chk("flf_inst", inst, 32'h2222_2222);
    chk("flf_inst_pc", pc, 32'h500);
    $display("fetch pc=%h inst=%h", pc, inst);

    // Flush beats branch on a consume cycle; target the top word
    flush = 1'b1; flush_pc = 32'hFFFF_FFFF; br_take = 1'b1; br_target = 32'h700;
    tick();
    flush = 1'b0; br_take = 1'b0;
    chk("prio_addr", imem_bus.addr, 32'hFFFF_FFFC);
    chk("prio_valid", {31'd0, inst_valid}, 32'd0);
    imem_bus.ready = 1'b1;
    tick();
    imem_bus.ready = 1'b0;
    imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'h3333_3333;
    tick();
    imem_bus.rvalid = 1'b0;
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick();
    chk("wrap_addr", imem_bus.addr, 32'h0);

    // Asynchronous reset mid-WAIT
    imem_bus.ready = 1'b1;
    tick();
    imem_bus.ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_req", {31'd0, imem_bus.req}, 32'd0);
    chk("arst_inst", inst, 32'h13);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_rel_req", {31'd0, imem_bus.req}, 32'd1);
    $display("reset -> pc=%h", pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
